// File: rtl/led_status_driver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// led_status_driver
//
// Purpose:
//   Takes the CPU's 32-bit csr word and drives the six board LEDs. The word is
//   decoded into per-LED on/blink enables, a global PWM brightness and a blink
//   rate. Changes are captured into a shadow register only at PWM frame
//   boundaries, so the LED waveform never glitches mid-frame.
//
//   csr fields: [5:0] on, [11:6] blink, [15:12] duty d, [17:16] rate r,
//               [31:18] unused.
//
// Configuration:
//   LED_GAMMA_EN  defined   -> duty_eff = GAMMA[d] (perceptual table)
//                 undefined -> duty_eff = d + 1    (linear)
//   Both mappings send d=15 to 16, i.e. always on.
//
// Parameters:
//   PWM_DIV            clk cycles per PWM step (>=1); frame = 16*PWM_DIV cycles
//   BLINK_HALF_CYCLES  blink half-period at rate 0, in clk cycles (>=8)
//
// Ports:
//   clk          in   CPU clock
//   rst_n        in   asynchronous active-low reset
//   csr[31:0]    in   CPU control/status word
//   leds[5:0]    out  registered LED drive, 1 = lit
//   frame_start  out  1-cycle pulse on the cycle the shadow register holds
//                     freshly loaded csr bits
// -----------------------------------------------------------------------------
module led_status_driver #(
  parameter int PWM_DIV           = 64,
  parameter int BLINK_HALF_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] csr,
  output logic [5:0]  leds,
  output logic        frame_start
);

  localparam int PRE_W   = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int BLINK_W = $clog2(BLINK_HALF_CYCLES);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_DIV - 1);

  // Terminal blink count per rate; H = BLINK_HALF_CYCLES >> r, last = H-1.
  // H itself may need one more bit than the counter, H-1 never does.
  localparam logic [BLINK_W-1:0] BLINK_LAST0 = BLINK_W'((BLINK_HALF_CYCLES >> 0) - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST1 = BLINK_W'((BLINK_HALF_CYCLES >> 1) - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST2 = BLINK_W'((BLINK_HALF_CYCLES >> 2) - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST3 = BLINK_W'((BLINK_HALF_CYCLES >> 3) - 1);

  // Upper csr bits carry nothing for this block.
  logic csr_unused;
  assign csr_unused = ^csr[31:18];

  // State
  logic [PRE_W-1:0]   pre_q,         pre_d;
  logic [3:0]         pwm_cnt_q,     pwm_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q,   blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [17:0]        shadow_q,      shadow_d;
  logic [5:0]         leds_q,        leds_d;
  logic               frame_start_q, frame_start_d;

  // Decoded shadow fields
  logic [5:0] sh_on;
  logic [5:0] sh_blink;
  logic [3:0] sh_duty;
  logic [1:0] sh_rate;

  assign sh_on    = shadow_q[5:0];
  assign sh_blink = shadow_q[11:6];
  assign sh_duty  = shadow_q[15:12];
  assign sh_rate  = shadow_q[17:16];

`ifdef LED_GAMMA_EN
  function automatic logic [4:0] duty_map(input logic [3:0] d);
    logic [4:0] r;
    case (d)
      4'd0, 4'd1, 4'd2, 4'd3: r = 5'd1;
      4'd4, 4'd5:             r = 5'd2;
      4'd6, 4'd7:             r = 5'd3;
      4'd8:                   r = 5'd4;
      4'd9:                   r = 5'd5;
      4'd10:                  r = 5'd6;
      4'd11:                  r = 5'd7;
      4'd12:                  r = 5'd9;
      4'd13:                  r = 5'd11;
      4'd14:                  r = 5'd13;
      default:                r = 5'd16;
    endcase
    return r;
  endfunction
`else
  function automatic logic [4:0] duty_map(input logic [3:0] d);
    return {1'b0, d} + 5'd1;
  endfunction
`endif

  logic               pre_wrap;
  logic               load;
  logic               rate_change;
  logic [BLINK_W-1:0] blink_last;
  logic               blink_wrap;
  logic [4:0]         duty_eff;
  logic               pwm_on;

  always_comb begin
    pre_wrap    = (pre_q == PRE_LAST);
    // Last prescaler cycle of the last PWM step closes the frame.
    load        = pre_wrap && (pwm_cnt_q == 4'd15);
    rate_change = load && (csr[17:16] != sh_rate);

    case (sh_rate)
      2'd0:    blink_last = BLINK_LAST0;
      2'd1:    blink_last = BLINK_LAST1;
      2'd2:    blink_last = BLINK_LAST2;
      default: blink_last = BLINK_LAST3;
    endcase
    blink_wrap = (blink_cnt_q == blink_last);

    duty_eff = duty_map(sh_duty);
    pwm_on   = ({1'b0, pwm_cnt_q} < duty_eff);
  end

  always_comb begin
    pre_d         = pre_wrap ? '0 : pre_q + 1'b1;
    pwm_cnt_d     = pre_wrap ? pwm_cnt_q + 4'd1 : pwm_cnt_q;
    shadow_d      = load ? csr[17:0] : shadow_q;
    frame_start_d = load;

    // A rate change restarts the half-period from zero; it wins over a wrap
    // on the same cycle, but the wrap still flips the phase.
    if (rate_change) begin
      blink_cnt_d = '0;
    end else if (blink_wrap) begin
      blink_cnt_d = '0;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
    blink_phase_d = blink_phase_q ^ blink_wrap;

    leds_d = sh_on & {6{pwm_on}} & (~sh_blink | {6{blink_phase_q}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q         <= '0;
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      shadow_q      <= '0;
      leds_q        <= '0;
      frame_start_q <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      shadow_q      <= shadow_d;
      leds_q        <= leds_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign leds        = leds_q;
  assign frame_start = frame_start_q;

endmodule
